// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
// Shared constants for the writeback arbiter slice: register-file geometry,
// default requester count and the round-robin pointer advance helper.
// No ports (package).
package regfile_wb_arbiter_pkg;

   localparam int REG_NUM_LOG2 = 5;   // register address width
   localparam int REG_BUS_W    = 32;  // register data width
   localparam int WB_REQ_NUM   = 2;   // default number of writeback sources

   // Advance a round-robin index by one with wrap to 0 after n-1.
   function automatic int rr_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational N-way round-robin pick. Scans from ptr upward (mod N) and
// grants the first valid source.
// Ports:
//   valid     in   N      request vector
//   ptr       in   IDX_W  highest-priority source index
//   grant     out  N      one-hot grant, zero when nothing is valid
//   grant_idx out  IDX_W  index of the granted source (0 when none)
//   grant_any out  1      a grant was issued
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int N     = WB_REQ_NUM,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] cand_idx;

   // Walk offsets from farthest to nearest so the nearest valid source
   // (lowest offset from ptr) is the last one written and therefore wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand_idx  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand_idx = IDX_W'((int'(ptr) + k) % N);
         if (valid[cand_idx]) begin
            grant           = '0;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
            grant_any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register-file write port among NUM_REQ writeback sources with
// round-robin arbitration and a registered write stage.
// Ports:
//   clk       in   1               clock
//   rst       in   1               asynchronous reset, active low
//   hold      in   1               suppress all new grants this cycle
//   req_valid in   NUM_REQ         per-source write request
//   req_addr  in   NUM_REQ*ADDR_W  packed destination addresses
//   req_data  in   NUM_REQ*DATA_W  packed write data
//   req_ready out  NUM_REQ         one-hot/zero combinational grant
//   we        out  1               register-file write enable (registered)
//   waddr     out  ADDR_W          register-file write address (registered)
//   wdata     out  DATA_W          register-file write data (registered)
//   busy      out  1               some valid request was not granted
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = WB_REQ_NUM,
   parameter int ADDR_W  = REG_NUM_LOG2,
   parameter int DATA_W  = REG_BUS_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        hold,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        we,
   output logic [ADDR_W-1:0]           waddr,
   output logic [DATA_W-1:0]           wdata,
   output logic                        busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   ptr_reg, ptr_next;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_any;
   logic               commit;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               we_reg;
   logic [ADDR_W-1:0]  waddr_reg;
   logic [DATA_W-1:0]  wdata_reg;

   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   logic [DATA_W-1:0]  data_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Grants are masked off entirely during reset and hold, so the arbiter
   // only ever sees valid bits; address/data never influence ready.
   assign eligible = (rst && !hold) ? req_valid : '0;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .valid     (eligible),
      .ptr       (ptr_reg),
      .grant     (grant_onehot),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant_onehot;
   assign busy      = |(req_valid & ~grant_onehot);

   assign sel_addr = addr_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   // Writes to register 0 complete the handshake but are never committed.
   assign commit = grant_any && (sel_addr != '0);

   always_comb begin
      ptr_next = ptr_reg;
      if (grant_any) begin
         ptr_next = IDX_W'(rr_wrap_inc(int'(grant_idx), NUM_REQ));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg   <= '0;
         we_reg    <= 1'b0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
         we_reg  <= commit;
         if (commit) begin
            waddr_reg <= sel_addr;
            wdata_reg <= sel_data;
         end
      end
   end

   assign we    = we_reg;
   assign waddr = waddr_reg;
   assign wdata = wdata_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int N  = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            hold = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic            busy;

   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;

   int n_cmp = 0;
   int n_bad = 0;
   bit done  = 1'b0;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_ptr   = 0;
   bit            m_we    = 1'b0;
   logic [AW-1:0] m_waddr = '0;
   logic [DW-1:0] m_wdata = '0;

   // Winner: first valid source at or after p, wrapping; -1 if none.
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int model_grant();
      if (!rst || hold) return -1;
      return pick(req_valid, m_ptr);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ptr   <= 0;
         m_we    <= 1'b0;
         m_waddr <= '0;
         m_wdata <= '0;
      end else begin
         int g;
         g = model_grant();
         if (g >= 0) begin
            m_ptr <= (g + 1) % N;
            m_we  <= (req_addr[g*AW +: AW] != 0);
            if (req_addr[g*AW +: AW] != 0) begin
               m_waddr <= req_addr[g*AW +: AW];
               m_wdata <= req_data[g*DW +: DW];
            end
         end else begin
            m_we <= 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (!done) begin
         int g;
         logic [N-1:0] exp_ready;
         g = model_grant();
         exp_ready = (g >= 0) ? N'(1 << g) : '0;
         check("cyc_ready", 32'(req_ready), 32'(exp_ready));
         check("cyc_busy", 32'(busy), 32'(|(req_valid & ~exp_ready)));
         check("cyc_we", 32'(we), 32'(m_we));
         if (m_we) begin
            check("cyc_waddr", 32'(waddr), 32'(m_waddr));
            check("cyc_wdata", wdata, m_wdata);
         end
         $display("cyc t=%0t rst=%0b hold=%0b valid=%b ready=%b we=%0b waddr=%0d wdata=%h busy=%0b",
                  $time, rst, hold, req_valid, req_ready, we, waddr, wdata, busy);
      end
   end

   // Apply one cycle of stimulus 2 time units after the edge; return at +3.
   task automatic drive(input logic h, input logic [N-1:0] v);
      @(posedge clk);
      #2;
      hold      = h;
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      // 1. Reset with both sources requesting
      a0 = 5'd7; d0 = 32'h0000_00A0; a1 = 5'd9; d1 = 32'h0000_00B1;
      drive(1'b0, 2'b11);
      drive(1'b0, 2'b11);
      check("t1_rst_ready", 32'(req_ready), 32'h0);
      check("t1_rst_we", 32'(we), 32'h0);
      check("t1_rst_busy", 32'(busy), 32'h1);
      @(posedge clk); #2; rst = 1'b1; #1;
      check("t1_first_ready", 32'(req_ready), 32'b01);
      drive(1'b0, 2'b10);
      check("t1_ptr_is_1", 32'(req_ready), 32'b10);
      check("t1_we", 32'(we), 32'h1);
      check("t1_waddr", 32'(waddr), 32'd7);
      check("t1_wdata", wdata, 32'h0000_00A0);
      drive(1'b0, 2'b00);
      check("t1_waddr_src1", 32'(waddr), 32'd9);

      // 2. Single source
      a1 = 5'd5; d1 = 32'hDEADBEEF;
      drive(1'b0, 2'b10);
      check("t2_ready", 32'(req_ready), 32'b10);
      drive(1'b0, 2'b00);
      check("t2_we", 32'(we), 32'h1);
      check("t2_waddr", 32'(waddr), 32'd5);
      check("t2_wdata", wdata, 32'hDEADBEEF);

      // 3. Round-robin with both continuously valid
      a0 = 5'd1; d0 = 32'h1111_0001; a1 = 5'd2; d1 = 32'h2222_0002;
      drive(1'b0, 2'b11);
      check("t3_g0", 32'(req_ready), 32'b01);
      check("t3_busy0", 32'(busy), 32'h1);
      a0 = 5'd3; d0 = 32'h1111_0003;
      drive(1'b0, 2'b11);
      check("t3_g1", 32'(req_ready), 32'b10);
      a1 = 5'd4; d1 = 32'h2222_0004;
      drive(1'b0, 2'b11);
      check("t3_g2", 32'(req_ready), 32'b01);
      check("t3_we2", 32'(we), 32'h1);
      drive(1'b0, 2'b11);
      check("t3_g3", 32'(req_ready), 32'b10);
      check("t3_busy3", 32'(busy), 32'h1);
      drive(1'b0, 2'b00);
      check("t3_we_last", 32'(we), 32'h1);
      check("t3_waddr_last", 32'(waddr), 32'd4);

      // 4. Write to x0 is accepted but dropped
      a0 = 5'd0; d0 = 32'h0000_1234;
      drive(1'b0, 2'b01);
      check("t4_x0_ready", 32'(req_ready), 32'b01);
      a0 = 5'd3; d0 = 32'h0000_5555;
      drive(1'b0, 2'b01);
      check("t4_x0_we", 32'(we), 32'h0);
      drive(1'b0, 2'b00);
      check("t4_we", 32'(we), 32'h1);
      check("t4_waddr", 32'(waddr), 32'd3);

      // 5. hold blocks grants and keeps ptr (ptr=1 here)
      a0 = 5'd10; d0 = 32'hAAAA_0010; a1 = 5'd11; d1 = 32'hBBBB_0011;
      drive(1'b1, 2'b11);
      check("t5_hold_ready", 32'(req_ready), 32'h0);
      check("t5_hold_busy", 32'(busy), 32'h1);
      drive(1'b1, 2'b11);
      check("t5_hold_we", 32'(we), 32'h0);
      drive(1'b0, 2'b11);
      check("t5_resume", 32'(req_ready), 32'b10);
      drive(1'b0, 2'b01);
      check("t5_then_src0", 32'(req_ready), 32'b01);
      check("t5_waddr", 32'(waddr), 32'd11);
      drive(1'b0, 2'b00);

      // 6. Reset in the middle of an in-flight write (ptr=1 here)
      a0 = 5'd12; d0 = 32'hCCCC_0012; a1 = 5'd13; d1 = 32'hDDDD_0013;
      drive(1'b0, 2'b11);
      check("t6_grant1", 32'(req_ready), 32'b10);
      @(posedge clk); #1;
      check("t6_we_inflight", 32'(we), 32'h1);
      #1; rst = 1'b0; #1;
      check("t6_async_we", 32'(we), 32'h0);
      check("t6_rst_ready", 32'(req_ready), 32'h0);
      drive(1'b0, 2'b11);
      drive(1'b0, 2'b11);
      @(posedge clk); #2; rst = 1'b1; #1;
      check("t6_post_rel", 32'(req_ready), 32'b01);
      drive(1'b0, 2'b10);
      check("t6_post_rel2", 32'(req_ready), 32'b10);
      drive(1'b0, 2'b00);
      drive(1'b0, 2'b00);

      @(posedge clk); #1;
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
